// File: rtl/psum_mem_arbiter_if.sv
// Bundle of the controller, host and memory-side signals of the partial-sum memory arbiter.
// Handshake: req/we/addr/wdata form the request and are held until gnt; an access happens in a cycle with req && gnt. rvalid is a one-cycle pulse with no back-pressure.
interface psum_mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic              ctrl_req;
  logic              ctrl_we;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_wdata;
  logic              ctrl_gnt;
  logic              ctrl_rvalid;
  logic [DATA_W-1:0] ctrl_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [31:0]       ctrl_stall_cnt;
  logic              dbg_state;
  logic [7:0]        dbg_wait_cnt;

  modport slave (
    input  ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output ctrl_gnt, ctrl_rvalid, ctrl_rdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output ctrl_stall_cnt, dbg_state, dbg_wait_cnt
  );

  modport master (
    output ctrl_req, ctrl_we, ctrl_addr, ctrl_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  ctrl_gnt, ctrl_rvalid, ctrl_rdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  ctrl_stall_cnt, dbg_state, dbg_wait_cnt
  );
endinterface

// File: rtl/psum_mem_arbiter.sv
// Single-port partial-sum memory arbiter: controller has priority, host is forced
// through after MAX_WAIT consecutive refusals; read data is steered back to its issuer.
module psum_mem_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              arst_in,
  psum_mem_arbiter_if.slave bus
);

  typedef enum logic {
    CTRL_PRIO   = 1'b0,
    HOST_FORCED = 1'b1
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic              rd_owner_valid;
  logic              rd_owner;
  logic [31:0]       stall_cnt;

  logic              ctrl_gnt;
  logic              host_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Grants are held low during reset so nothing reaches the memory.
  always_comb begin
    ctrl_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!arst_in) begin
      if (state == HOST_FORCED) begin
        host_gnt = bus.host_req;
        ctrl_gnt = bus.ctrl_req && !bus.host_req;
      end else begin
        ctrl_gnt = bus.ctrl_req;
        host_gnt = bus.host_req && !bus.ctrl_req;
      end
    end
  end

  always_comb begin
    mem_en    = ctrl_gnt || host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ctrl_gnt) begin
      mem_we    = bus.ctrl_we;
      mem_addr  = bus.ctrl_addr;
      mem_wdata = bus.ctrl_wdata;
    end else if (host_gnt) begin
      mem_we    = bus.host_we;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state          <= CTRL_PRIO;
      wait_cnt       <= 8'd0;
      rd_owner_valid <= 1'b0;
      rd_owner       <= 1'b0;
      stall_cnt      <= 32'd0;
    end else begin
      if (state == CTRL_PRIO) begin
        if (bus.host_req && !host_gnt && wait_cnt == WAIT_LAST) state <= HOST_FORCED;
      end else begin
        if (host_gnt || !bus.host_req) state <= CTRL_PRIO;
      end

      // A withdrawn host request loses its accumulated wait.
      if (host_gnt || !bus.host_req) begin
        wait_cnt <= 8'd0;
      end else if (state == CTRL_PRIO && wait_cnt != WAIT_LAST) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      rd_owner_valid <= mem_en && !mem_we;
      rd_owner       <= host_gnt;

      if (bus.ctrl_req && !ctrl_gnt && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign bus.ctrl_gnt       = ctrl_gnt;
  assign bus.host_gnt       = host_gnt;
  assign bus.mem_en         = mem_en;
  assign bus.mem_we         = mem_we;
  assign bus.mem_addr       = mem_addr;
  assign bus.mem_wdata      = mem_wdata;
  assign bus.ctrl_rvalid    = rd_owner_valid && !rd_owner;
  assign bus.host_rvalid    = rd_owner_valid && rd_owner;
  assign bus.ctrl_rdata     = (rd_owner_valid && !rd_owner) ? bus.mem_rdata : '0;
  assign bus.host_rdata     = (rd_owner_valid && rd_owner) ? bus.mem_rdata : '0;
  assign bus.ctrl_stall_cnt = stall_cnt;
  assign bus.dbg_state      = state;
  assign bus.dbg_wait_cnt   = wait_cnt;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// Bench for psum_mem_arbiter: directed scenarios then random traffic, all checked
// against a request-level model (refusal count, model memory, expected read queue).
module tb_psum_mem_arbiter;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  logic clk = 1'b0;
  logic arst_in;
  always #5 clk = ~clk;

  psum_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  psum_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk     (clk),
    .arst_in (arst_in),
    .bus     (bus.slave)
  );

  // Memory behind the arbiter: one-cycle read latency, cleared on reset.
  logic [DATA_W-1:0] tb_mem [16];
  always @(posedge clk) begin
    if (arst_in) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= '0;
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= tb_mem[bus.mem_addr[3:0]];
    end
  end

  int                checks;
  int                failures;
  int                refusals;
  logic [31:0]       m_stall;
  logic [DATA_W-1:0] m_mem [16];
  logic [DATA_W:0]   exp_q[$];
  logic              m_cg, m_hg;
  logic              obs_cg, obs_hg;
  int                first;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    refusals = 0;
    m_stall  = 32'd0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
  endtask

  task automatic set_ctrl(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    bus.ctrl_req   = req;
    bus.ctrl_we    = we;
    bus.ctrl_addr  = ADDR_W'(addr);
    bus.ctrl_wdata = wd;
  endtask

  task automatic set_host(input logic req, input logic we, input int addr, input logic [DATA_W-1:0] wd);
    bus.host_req   = req;
    bus.host_we    = we;
    bus.host_addr  = ADDR_W'(addr);
    bus.host_wdata = wd;
  endtask

  // Called at posedge+1 with inputs set; checks this cycle, then advances the model at the edge.
  task automatic step();
    logic [DATA_W:0]   e;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              ewe;
    #1;
    if (arst_in) begin
      m_cg = 1'b0;
      m_hg = 1'b0;
    end else begin
      m_hg = bus.host_req && (!bus.ctrl_req || refusals >= MAX_WAIT);
      m_cg = bus.ctrl_req && !m_hg;
    end
    ewe = m_cg ? bus.ctrl_we    : (m_hg ? bus.host_we    : 1'b0);
    ea  = m_cg ? bus.ctrl_addr  : (m_hg ? bus.host_addr  : '0);
    ed  = m_cg ? bus.ctrl_wdata : (m_hg ? bus.host_wdata : '0);
    obs_cg = bus.ctrl_gnt;
    obs_hg = bus.host_gnt;
    chk("ctrl_gnt",  64'(bus.ctrl_gnt),  64'(m_cg));
    chk("host_gnt",  64'(bus.host_gnt),  64'(m_hg));
    chk("mem_en",    64'(bus.mem_en),    64'(m_cg || m_hg));
    chk("mem_we",    64'(bus.mem_we),    64'(ewe));
    chk("mem_addr",  64'(bus.mem_addr),  64'(ea));
    chk("mem_wdata", 64'(bus.mem_wdata), 64'(ed));
    chk("stall_cnt", 64'(bus.ctrl_stall_cnt), 64'(m_stall));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ctrl_rvalid", 64'(bus.ctrl_rvalid), 64'(!e[DATA_W]));
      chk("host_rvalid", 64'(bus.host_rvalid), 64'(e[DATA_W]));
      chk("ctrl_rdata",  64'(bus.ctrl_rdata),  e[DATA_W] ? 64'(0) : 64'(e[DATA_W-1:0]));
      chk("host_rdata",  64'(bus.host_rdata),  e[DATA_W] ? 64'(e[DATA_W-1:0]) : 64'(0));
    end else begin
      chk("ctrl_rvalid_idle", 64'(bus.ctrl_rvalid), 64'(0));
      chk("host_rvalid_idle", 64'(bus.host_rvalid), 64'(0));
      chk("ctrl_rdata_idle",  64'(bus.ctrl_rdata),  64'(0));
      chk("host_rdata_idle",  64'(bus.host_rdata),  64'(0));
    end
    @(posedge clk);
    if (!arst_in) begin
      if (m_hg || !bus.host_req) refusals = 0;
      else                       refusals++;
      if (bus.ctrl_req && !m_cg && m_stall != 32'hFFFF_FFFF) m_stall++;
      if ((m_cg || m_hg) && !ewe) exp_q.push_back({m_hg, m_mem[ea[3:0]]});
      if ((m_cg || m_hg) && ewe)  m_mem[ea[3:0]] = ed;
    end
    #1;
  endtask

  task automatic pulse_reset();
    arst_in = 1'b1;
    model_reset();
    step();
    arst_in = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    arst_in  = 1'b1;
    model_reset();
    set_ctrl(1'b1, 1'b0, 0, '0);
    set_host(1'b1, 1'b0, 1, '0);
    @(posedge clk);
    #1;

    // Reset hold with both requesting
    step();
    step();
    chk("rst_state", 64'(bus.dbg_state), 64'(0));
    chk("rst_wait",  64'(bus.dbg_wait_cnt), 64'(0));
    arst_in = 1'b0;
    step();
    chk("post_rst_ctrl_gnt", 64'(obs_cg), 64'(1));
    chk("post_rst_host_gnt", 64'(obs_hg), 64'(0));
    set_ctrl(1'b0, 1'b0, 0, '0);
    set_host(1'b0, 1'b0, 0, '0);
    step();

    // Controller-only write then read
    set_ctrl(1'b1, 1'b1, 5, 32'hDEAD);
    step();
    set_ctrl(1'b1, 1'b0, 5, '0);
    step();
    chk("dead_rvalid", 64'(bus.ctrl_rvalid), 64'(1));
    chk("dead_rdata",  64'(bus.ctrl_rdata),  64'(32'hDEAD));
    chk("dead_host_rv", 64'(bus.host_rvalid), 64'(0));
    set_ctrl(1'b0, 1'b0, 0, '0);
    step();

    // Starvation bound under continuous controller load
    pulse_reset();
    set_ctrl(1'b1, 1'b0, 1, '0);
    set_host(1'b1, 1'b0, 3, '0);
    first = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (obs_hg && first < 0) begin
        first = c;
        chk("starve_ctrl_gnt", 64'(obs_cg), 64'(0));
        chk("starve_stall", 64'(bus.ctrl_stall_cnt), 64'(1));
        set_host(1'b0, 1'b0, 0, '0);
        chk("starve_back_prio", 64'(bus.dbg_state), 64'(0));
      end
    end
    chk("starve_first_gnt", 64'(first), 64'(MAX_WAIT));
    set_ctrl(1'b0, 1'b0, 0, '0);
    step();

    // Alternating owners, back-to-back reads
    set_ctrl(1'b1, 1'b1, 3, 32'h11);
    step();
    set_ctrl(1'b1, 1'b1, 4, 32'h22);
    step();
    set_ctrl(1'b0, 1'b0, 0, '0);
    set_host(1'b1, 1'b0, 3, '0);
    step();
    set_host(1'b0, 1'b0, 0, '0);
    set_ctrl(1'b1, 1'b0, 4, '0);
    chk("alt_host_rv", 64'(bus.host_rvalid), 64'(1));
    chk("alt_host_rd", 64'(bus.host_rdata),  64'(32'h11));
    step();
    chk("alt_ctrl_rv", 64'(bus.ctrl_rvalid), 64'(1));
    chk("alt_ctrl_rd", 64'(bus.ctrl_rdata),  64'(32'h22));
    chk("alt_host_rv_low", 64'(bus.host_rvalid), 64'(0));
    set_ctrl(1'b0, 1'b0, 0, '0);
    step();

    // Host request withdrawn after 5 refused cycles
    set_ctrl(1'b1, 1'b0, 2, '0);
    set_host(1'b1, 1'b1, 7, 32'h55);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("wd_no_gnt", 64'(obs_hg), 64'(0));
    end
    set_host(1'b0, 1'b0, 0, '0);
    step();
    chk("wd_wait_clr", 64'(bus.dbg_wait_cnt), 64'(0));
    chk("wd_state", 64'(bus.dbg_state), 64'(0));
    set_host(1'b1, 1'b1, 7, 32'h55);
    first = -1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (obs_hg && first < 0) begin
        first = c;
        set_host(1'b0, 1'b0, 0, '0);
      end
    end
    chk("wd_full_wait", 64'(first), 64'(MAX_WAIT));
    set_ctrl(1'b0, 1'b0, 0, '0);
    step();

    // Reset while a host read is outstanding
    set_host(1'b1, 1'b0, 4, '0);
    step();
    chk("mid_rst_gnt", 64'(obs_hg), 64'(1));
    set_host(1'b0, 1'b0, 0, '0);
    arst_in = 1'b1;
    model_reset();
    #2;
    chk("mid_rst_host_rv", 64'(bus.host_rvalid), 64'(0));
    chk("mid_rst_stall", 64'(bus.ctrl_stall_cnt), 64'(0));
    chk("mid_rst_state", 64'(bus.dbg_state), 64'(0));
    step();
    arst_in = 1'b0;
    step();
    step();

    // Random traffic with hold-until-grant requesters and occasional host withdrawal
    for (int i = 0; i < 600; i++) begin
      step();
      if (bus.ctrl_req && m_cg) bus.ctrl_req = 1'b0;
      if (!bus.ctrl_req && $urandom_range(0, 3) != 0)
        set_ctrl(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
      if (bus.host_req && m_hg) begin
        bus.host_req = 1'b0;
      end else if (bus.host_req && $urandom_range(0, 15) == 0) begin
        bus.host_req = 1'b0;
        continue;
      end
      if (!bus.host_req && $urandom_range(0, 2) == 0)
        set_host(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom);
    end
    set_ctrl(1'b0, 1'b0, 0, '0);
    set_host(1'b0, 1'b0, 0, '0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
